pc_stack_counter: RTL and testbench

Parametrised program counter with WIDTH-bit count, parallel load, signed relative branch, and a STACK_DEPTH-entry hardware return stack for call/return. Sits between the instruction sequencer and the shared address bus. The bus-drive enable is registered, so the bus owner sees the PC one cycle after requesting it. Internal tri-states are replaced by an explicit output-enable plus a zero-gated output.

---
 rtl/pc_stack_counter.sv | 133 +++++++++++++
 tb/tb_pc_stack_counter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_counter.sv
//==============================================================================
// Module   : pc_stack_counter
// Purpose  : Program counter with load, relative branch, call/return stack,
//            a registered bus-drive enable and sticky stack error flags.
// Revision : 1.0
//==============================================================================
`default_nettype none

module pc_stack_counter #(
    parameter int               WIDTH        = 8,
    parameter int               STACK_DEPTH  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               inc,
    input  logic                               load,
    input  logic                               branch,
    input  logic                               call,
    input  logic                               ret,
    input  logic                               out_en,
    input  logic                               err_clr,
    input  logic [WIDTH-1:0]                   din,
    output logic [WIDTH-1:0]                   pc_out,
    output logic                               pc_oe,
    output logic [WIDTH-1:0]                   pc_q,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               wrap,
    output logic                               err_ovf,
    output logic                               err_unf
);

    localparam int SPW  = $clog2(STACK_DEPTH + 1);
    localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [WIDTH-1:0] pc_cur_q, pc_cur_d;
    logic [SPW-1:0]   sp_cur_q, sp_cur_d;
    logic             oe_q;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    logic             is_full;
    logic             is_empty;
    logic [IDXW-1:0]  push_idx;
    logic [IDXW-1:0]  pop_idx;
    logic [WIDTH-1:0] pc_plus1;

    assign is_full  = (sp_cur_q == SPW'(STACK_DEPTH));
    assign is_empty = (sp_cur_q == '0);
    assign push_idx = IDXW'(sp_cur_q);
    assign pop_idx  = IDXW'(sp_cur_q - SPW'(1));
    assign pc_plus1 = pc_cur_q + WIDTH'(1);

    // One action per cycle in priority order ret > call > load > branch > inc.
    always_comb begin
        pc_cur_d = pc_cur_q;
        sp_cur_d = sp_cur_q;
        wrap_d   = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        push     = 1'b0;
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (ret) begin
            if (is_empty) begin
                unf_d = 1'b1;
            end else begin
                pc_cur_d = stack_q[pop_idx];
                sp_cur_d = sp_cur_q - SPW'(1);
            end
        end else if (call) begin
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                push     = 1'b1;
                pc_cur_d = din;
                sp_cur_d = sp_cur_q + SPW'(1);
            end
        end else if (load) begin
            pc_cur_d = din;
        end else if (branch) begin
            pc_cur_d = pc_cur_q + din;
        end else if (inc) begin
            pc_cur_d = pc_plus1;
            wrap_d   = &pc_cur_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_cur_q <= RESET_VECTOR;
            sp_cur_q <= '0;
            oe_q     <= 1'b0;
            wrap_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            pc_cur_q <= pc_cur_d;
            sp_cur_q <= sp_cur_d;
            oe_q     <= out_en;
            wrap_q   <= wrap_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Stack contents carry no reset; only entries below sp are ever read.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            stack_q[push_idx] <= pc_plus1;
        end
    end

    assign pc_q        = pc_cur_q;
    assign pc_oe       = oe_q;
    assign pc_out      = oe_q ? pc_cur_q : '0;
    assign sp          = sp_cur_q;
    assign stack_full  = is_full;
    assign stack_empty = is_empty;
    assign wrap        = wrap_q;
    assign err_ovf     = ovf_q;
    assign err_unf     = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_stack_counter.sv
//==============================================================================
// Module   : tb_pc_stack_counter
// Purpose  : Directed vector table plus randomized run against a queue model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_pc_stack_counter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int RV    = 0;

    // Control byte bit positions for the vector table.
    localparam logic [7:0] R = 8'h80, I = 8'h40, L = 8'h20, B = 8'h10;
    localparam logic [7:0] C = 8'h08, P = 8'h04, O = 8'h02, E = 8'h01;

    logic             clk = 1'b0;
    logic             rst, inc, load, branch, call, ret, out_en, err_clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] pc_out, pc_q;
    logic             pc_oe, stack_full, stack_empty, wrap, err_ovf, err_unf;
    logic [2:0]       sp;

    int total = 0;
    int bad   = 0;

    pc_stack_counter #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH), .RESET_VECTOR(8'(RV))) dut (
        .clk(clk), .rst(rst), .inc(inc), .load(load), .branch(branch),
        .call(call), .ret(ret), .out_en(out_en), .err_clr(err_clr), .din(din),
        .pc_out(pc_out), .pc_oe(pc_oe), .pc_q(pc_q), .sp(sp),
        .stack_full(stack_full), .stack_empty(stack_empty), .wrap(wrap),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ctl;
        logic [7:0] din;
        logic [7:0] e_pc;
        int         e_sp;
        logic [3:0] e_flg;   // {wrap, ovf, unf, oe}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [7:0] ctl, input logic [7:0] d,
                               input logic [7:0] epc, input int esp,
                               input logic [3:0] flg);
        vec_t t;
        t.ctl = ctl; t.din = d; t.e_pc = epc; t.e_sp = esp; t.e_flg = flg;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] ctl, input logic [7:0] d);
        rst = ctl[7]; inc = ctl[6]; load = ctl[5]; branch = ctl[4];
        call = ctl[3]; ret = ctl[2]; out_en = ctl[1]; err_clr = ctl[0];
        din = d;
    endtask

    task automatic check_all(input string tag, input int epc, input int esp,
                             input logic ew, input logic eo, input logic eu,
                             input logic eoe);
        chk({tag, ".pc_q"},   int'(pc_q), epc);
        chk({tag, ".sp"},     int'(sp), esp);
        chk({tag, ".wrap"},   int'(wrap), int'(ew));
        chk({tag, ".ovf"},    int'(err_ovf), int'(eo));
        chk({tag, ".unf"},    int'(err_unf), int'(eu));
        chk({tag, ".oe"},     int'(pc_oe), int'(eoe));
        chk({tag, ".pc_out"}, int'(pc_out), eoe ? epc : 0);
        chk({tag, ".full"},   int'(stack_full), int'(esp == DEPTH));
        chk({tag, ".empty"},  int'(stack_empty), int'(esp == 0));
    endtask

    // Reference model state
    int m_pc, m_oe, m_wrap, m_ovf, m_unf;
    int m_stk[$];

    task automatic model_step(input logic [7:0] ctl, input logic [7:0] d);
        int off;
        m_wrap = 0;
        if (ctl[7]) begin
            m_pc = RV; m_stk.delete(); m_oe = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (ctl[0]) begin m_ovf = 0; m_unf = 0; end
            if (ctl[2]) begin
                if (m_stk.size() == 0) m_unf = 1;
                else m_pc = m_stk.pop_back();
            end else if (ctl[3]) begin
                if (m_stk.size() == DEPTH) m_ovf = 1;
                else begin m_stk.push_back((m_pc + 1) % 256); m_pc = int'(d); end
            end else if (ctl[5]) begin
                m_pc = int'(d);
            end else if (ctl[4]) begin
                off  = (d >= 128) ? int'(d) - 256 : int'(d);
                m_pc = (m_pc + off + 256) % 256;
            end else if (ctl[6]) begin
                m_wrap = (m_pc == 255) ? 1 : 0;
                m_pc   = (m_pc + 1) % 256;
            end
            m_oe = int'(ctl[1]);
        end
    endtask

    initial begin
        drive(8'h00, 8'h00);

        tbl.push_back(v(R,       8'h00, 8'h00, 0, 4'b0000));
        tbl.push_back(v(I|O,     8'h00, 8'h01, 0, 4'b0001));
        tbl.push_back(v(I|O,     8'h00, 8'h02, 0, 4'b0001));
        tbl.push_back(v(I|O,     8'h00, 8'h03, 0, 4'b0001));
        tbl.push_back(v(L|O,     8'hFE, 8'hFE, 0, 4'b0001));
        tbl.push_back(v(I|O,     8'h00, 8'hFF, 0, 4'b0001));
        tbl.push_back(v(I|O,     8'h00, 8'h00, 0, 4'b1001));
        tbl.push_back(v(8'h00,   8'h00, 8'h00, 0, 4'b0000));
        tbl.push_back(v(L|O,     8'h10, 8'h10, 0, 4'b0001));
        tbl.push_back(v(B|O,     8'hF0, 8'h00, 0, 4'b0001));
        tbl.push_back(v(B|O,     8'h05, 8'h05, 0, 4'b0001));
        tbl.push_back(v(L|O,     8'h20, 8'h20, 0, 4'b0001));
        tbl.push_back(v(C|O,     8'h40, 8'h40, 1, 4'b0001));
        tbl.push_back(v(C|O,     8'h60, 8'h60, 2, 4'b0001));
        tbl.push_back(v(P|O,     8'h00, 8'h41, 1, 4'b0001));
        tbl.push_back(v(P|O,     8'h00, 8'h21, 0, 4'b0001));
        tbl.push_back(v(P|O,     8'h00, 8'h21, 0, 4'b0011));
        tbl.push_back(v(E|O,     8'h00, 8'h21, 0, 4'b0001));
        tbl.push_back(v(C|O,     8'h01, 8'h01, 1, 4'b0001));
        tbl.push_back(v(C|O,     8'h02, 8'h02, 2, 4'b0001));
        tbl.push_back(v(C|O,     8'h03, 8'h03, 3, 4'b0001));
        tbl.push_back(v(C|O,     8'h04, 8'h04, 4, 4'b0001));
        tbl.push_back(v(C|O,     8'h05, 8'h04, 4, 4'b0101));
        tbl.push_back(v(P|O,     8'h00, 8'h04, 3, 4'b0101));
        tbl.push_back(v(P|O,     8'h00, 8'h03, 2, 4'b0101));
        tbl.push_back(v(P|O,     8'h00, 8'h02, 1, 4'b0101));
        tbl.push_back(v(P|O,     8'h00, 8'h22, 0, 4'b0101));
        tbl.push_back(v(P|O,     8'h00, 8'h22, 0, 4'b0111));
        tbl.push_back(v(P|E|O,   8'h00, 8'h22, 0, 4'b0011));
        tbl.push_back(v(E,       8'h00, 8'h22, 0, 4'b0000));
        tbl.push_back(v(C|O,     8'h30, 8'h30, 1, 4'b0001));
        tbl.push_back(v(P|C|I|O, 8'h77, 8'h23, 0, 4'b0001));
        tbl.push_back(v(L|I|O,   8'h99, 8'h99, 0, 4'b0001));
        tbl.push_back(v(B|I|O,   8'h02, 8'h9B, 0, 4'b0001));
        tbl.push_back(v(C|O,     8'h50, 8'h50, 1, 4'b0001));
        tbl.push_back(v(R|C|O,   8'h55, 8'h00, 0, 4'b0000));

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].ctl, tbl[k].din);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", k), int'(tbl[k].e_pc), tbl[k].e_sp,
                      tbl[k].e_flg[3], tbl[k].e_flg[2], tbl[k].e_flg[1],
                      tbl[k].e_flg[0]);
        end

        // Reset arriving mid call/return sequence with errors pending.
        @(negedge clk); drive(C|O, 8'hA0);
        @(negedge clk); drive(P|O, 8'h00);
        @(negedge clk); drive(P|O, 8'h00);
        @(negedge clk); drive(R|P|O, 8'h00);
        @(posedge clk); #1;
        check_all("midrst", RV, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized run against the reference model.
        model_step(R, 8'h00);
        @(negedge clk); drive(R, 8'h00);
        @(posedge clk); #1;
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] ctl;
            logic [7:0] d;
            ctl = '0;
            ctl[7] = ($urandom_range(0, 99) == 0);
            ctl[6] = ($urandom_range(0, 2) == 0);
            ctl[5] = ($urandom_range(0, 9) == 0);
            ctl[4] = ($urandom_range(0, 7) == 0);
            ctl[3] = ($urandom_range(0, 4) == 0);
            ctl[2] = ($urandom_range(0, 4) == 0);
            ctl[1] = ($urandom_range(0, 1) == 0);
            ctl[0] = ($urandom_range(0, 15) == 0);
            d = 8'($urandom);
            @(negedge clk);
            drive(ctl, d);
            model_step(ctl, d);
            @(posedge clk);
            #1;
            check_all("rnd", m_pc, m_stk.size(), m_wrap[0], m_ovf[0], m_unf[0], m_oe[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
